// File: rtl/alu_control_unit.sv
// ALU-side responder for the CPU control-unit handshake: single-cycle ADD/SUB/AND,
// shift-add MUL, and (when ALU_DIV_EN is defined) restoring unsigned DIV.
module alu_control_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ack,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags,
    output logic             err
);

    localparam int MSB = WIDTH - 1;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
`ifdef ALU_DIV_EN
    localparam logic [2:0] OP_DIV = 3'b100;
`endif

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        EXEC  = 5'b00010,
        MSTEP = 5'b00100,
`ifdef ALU_DIV_EN
        DSTEP = 5'b01000,
`endif
        DONE  = 5'b10000
    } state_t;

    state_t                 state_r, state_s;
    logic [2:0]             op_r;
    logic [WIDTH-1:0]       a_r, b_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [2*WIDTH-1:0]     work_r;
    logic                   last_step_s;
    logic [WIDTH:0]         add_s;
    logic [WIDTH-1:0]       diff_s;
    logic [WIDTH:0]         mul_sum_s;
    logic [2*WIDTH-1:0]     mul_next_s;
    logic [WIDTH-1:0]       exec_res_s, exec_hi_s;
    logic                   exec_c_s, exec_v_s, exec_err_s;
`ifdef ALU_DIV_EN
    logic [WIDTH:0]         div_trial_s;
    logic [2*WIDTH-1:0]     div_next_s;
`endif

    function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] res,
                                              input logic c, input logic v);
        make_flags = {res[MSB], (res == {WIDTH{1'b0}}), c, v};
    endfunction

    // Counter reaches WIDTH one cycle after the last iteration; that cycle registers the result.
    assign last_step_s = (cnt_r == CNT_W'(WIDTH));
    assign add_s       = {1'b0, a_r} + {1'b0, b_r};
    assign diff_s      = a_r - b_r;
    // work_r = {partial product high, multiplier shifting out LSB-first}
    assign mul_sum_s   = {1'b0, work_r[2*WIDTH-1:WIDTH]}
                       + (work_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
    assign mul_next_s  = {mul_sum_s, work_r[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    // work_r = {partial remainder, dividend shifting into quotient}
    assign div_trial_s = {work_r[2*WIDTH-1:WIDTH], work_r[MSB]} - {1'b0, b_r};
    assign div_next_s  = div_trial_s[WIDTH] ? {work_r[2*WIDTH-2:0], 1'b0}
                                            : {div_trial_s[MSB:0], work_r[WIDTH-2:0], 1'b1};
`endif

    assign ack  = state_r[4];
    assign busy = ~state_r[0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        state_s = MSTEP;
                    end
`ifdef ALU_DIV_EN
                    else if ((op == OP_DIV) && (b != {WIDTH{1'b0}})) begin
                        state_s = DSTEP;
                    end
`endif
                    else begin
                        state_s = EXEC;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC:  state_s = DONE;
            MSTEP: begin
                if (last_step_s) begin
                    state_s = DONE;
                end else begin
                    state_s = MSTEP;
                end
            end
`ifdef ALU_DIV_EN
            DSTEP: begin
                if (last_step_s) begin
                    state_s = DONE;
                end else begin
                    state_s = DSTEP;
                end
            end
`endif
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Single-cycle operation results; divide-by-zero is the only DIV case that reaches EXEC.
    always_comb begin
        exec_res_s = {WIDTH{1'b0}};
        exec_hi_s  = {WIDTH{1'b0}};
        exec_c_s   = 1'b0;
        exec_v_s   = 1'b0;
        exec_err_s = 1'b0;
        case (op_r)
            OP_ADD: begin
                exec_res_s = add_s[MSB:0];
                exec_c_s   = add_s[WIDTH];
                exec_v_s   = (a_r[MSB] == b_r[MSB]) && (add_s[MSB] != a_r[MSB]);
            end
            OP_SUB: begin
                exec_res_s = diff_s;
                exec_c_s   = (a_r >= b_r);
                exec_v_s   = (a_r[MSB] != b_r[MSB]) && (diff_s[MSB] != a_r[MSB]);
            end
            OP_AND: begin
                exec_res_s = a_r & b_r;
            end
`ifdef ALU_DIV_EN
            OP_DIV: begin
                exec_res_s = {WIDTH{1'b1}};
                exec_hi_s  = a_r;
                exec_err_s = 1'b1;
            end
`endif
            default: begin
                exec_err_s = 1'b1;
            end
        endcase
    end

    // Operand capture, iteration datapath and registered result/flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r      <= 3'b000;
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            work_r    <= {(2*WIDTH){1'b0}};
            result    <= {WIDTH{1'b0}};
            result_hi <= {WIDTH{1'b0}};
            flags     <= 4'b0000;
            err       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        op_r   <= op;
                        a_r    <= a;
                        b_r    <= b;
                        cnt_r  <= {CNT_W{1'b0}};
                        work_r <= (op == OP_MUL) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
                    end
                end
                EXEC: begin
                    result    <= exec_res_s;
                    result_hi <= exec_hi_s;
                    flags     <= make_flags(exec_res_s, exec_c_s, exec_v_s);
                    err       <= exec_err_s;
                end
                MSTEP: begin
                    if (last_step_s) begin
                        result    <= work_r[MSB:0];
                        result_hi <= work_r[2*WIDTH-1:WIDTH];
                        flags     <= make_flags(work_r[MSB:0],
                                                (work_r[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}}), 1'b0);
                        err       <= 1'b0;
                    end else begin
                        work_r <= mul_next_s;
                        cnt_r  <= cnt_r + CNT_W'(1);
                    end
                end
`ifdef ALU_DIV_EN
                DSTEP: begin
                    if (last_step_s) begin
                        result    <= work_r[MSB:0];
                        result_hi <= work_r[2*WIDTH-1:WIDTH];
                        flags     <= make_flags(work_r[MSB:0], 1'b0, 1'b0);
                        err       <= 1'b0;
                    end else begin
                        work_r <= div_next_s;
                        cnt_r  <= cnt_r + CNT_W'(1);
                    end
                end
`endif
                default: begin
                    op_r <= op_r;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_control_unit.md
Name: alu_control_unit

Overview:
- ALU-side responder for the CPU control unit's ALU handshake.
- The CPU pulses `start` for one cycle with operands and opcode, then waits until `ack` is seen. This block sequences the datapath and returns the result with a one-cycle `ack`.
- Single-cycle ops (ADD/SUB/AND) and a multi-cycle shift-add MUL; optional restoring DIV.
- Internal control is a one-hot state register.

Parameters:
WIDTH, 16, operand/result width in bits
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request pulse from CPU control unit
op  input  3  operation code, sampled with start
a  input  WIDTH  operand A, sampled with start
b  input  WIDTH  operand B, sampled with start
ack  output  1  one-cycle completion pulse; result/flags valid in same cycle
busy  output  1  high from cycle after accepted start through the ack cycle
result  output  WIDTH  primary result (sum/difference/AND/product low/quotient)
result_hi  output  WIDTH  product high half or remainder; 0 for other ops
flags  output  4  {N,Z,C,V} of result
err  output  1  illegal opcode or divide-by-zero, valid with ack

Behaviour:
- Reset (synchronous, rst=1 at a rising edge): state=IDLE.
  - `ack`, `busy`, `err` = 0; `result`, `result_hi`, `flags` = 0; counter = 0.
  - Applies mid-operation: the operation is abandoned and no `ack` is issued.
- States (one-hot): IDLE, EXEC, MSTEP, DSTEP, DONE.
- IDLE:
  - On start=1, latch `a`, `b` and `op` into internal registers.
  - Next state: EXEC for op 000/001/010; MSTEP for op 011; DSTEP for op 100 (see Optional Feature); EXEC otherwise.
  - start=0: remain in IDLE.
- Opcodes:
  - 000 ADD: `result`=A+B.
  - 001 SUB: `result`=A-B.
  - 010 AND: `result`=A&B.
  - 011 MUL: unsigned WIDTH x WIDTH product; {`result_hi`,`result`}=A*B.
  - 1xx: illegal when DIV is not enabled.
- EXEC: compute the single-cycle op, register result/flags, go to DONE. Illegal op: `result`=0, `err`=1.
- MSTEP: one shift-add iteration per cycle. Counter runs 0..WIDTH-1; after WIDTH iterations go to DONE.
- DONE: `ack`=1 for exactly this cycle; next state IDLE.
- Latency, with start high in cycle 0:
  - ADD/SUB/AND/illegal: `ack` in cycle 2.
  - MUL: `ack` in cycle WIDTH+2 (cycle 18 at default width).
- `busy`: high in cycles 1..ack cycle, low in IDLE.
- start while `busy`=1: ignored, latched operands are unchanged. start in the DONE cycle is also ignored; the CPU must not re-request before observing `ack`.
- `result`/`result_hi`/`flags`/`err` hold their values after DONE until the next accepted operation completes. They are not cleared on accept.
- Flags:
  - Z = (`result`==0).
  - N = `result`[WIDTH-1].
  - C:
    - ADD: carry-out.
    - SUB: 1 iff A>=B unsigned (no borrow).
    - MUL: 1 iff `result_hi`!=0.
    - AND/DIV/illegal: 0.
  - V:
    - ADD/SUB: two's-complement signed overflow.
    - All other ops: 0.
- Arithmetic is modulo 2^WIDTH; no saturation.

Optional Feature:
- Macro: `ALU_DIV_EN`.
- Defined:
  - op 100 = unsigned restoring DIV: `result`=A/B, `result_hi`=A%B.
  - DSTEP does one iteration per cycle for WIDTH cycles, then DONE; `ack` in cycle WIDTH+2.
  - Divide by zero (B==0) skips DSTEP: EXEC→DONE with `ack` in cycle 2, `result`=all ones, `result_hi`=A, `err`=1.
  - Ops 101..111 are illegal.
- Not defined: no DSTEP state or divider logic; all 1xx opcodes are illegal (`ack` cycle 2, `result`=0, `err`=1).

Test Plan:
- ADD, a=0x7FFF, b=0x0001, op=000 -> `ack` exactly in cycle 2; `result`=0x8000; flags N=1,Z=0,C=0,V=1; `err`=0; `busy` high in cycles 1-2.
- SUB, a=0x0003, b=0x0005, op=001 -> `result`=0xFFFE; C=0, N=1, V=0. Then AND a=0x0F0F, b=0x00FF -> `result`=0x000F, `ack` cycle 2.
- MUL, a=0x1234, b=0x0100, op=011 -> `ack` in cycle 18 only; `result`=0x3400, `result_hi`=0x0012, C=1. Extra start pulses in cycles 5 and 10 are ignored and the result is unchanged.
- rst asserted in cycle 8 of a MUL -> no `ack` ever; all outputs 0 next cycle. A following ADD 2+3 gives `result`=0x0005 with `ack` in cycle 2.
- op=101 without `ALU_DIV_EN` -> `ack` cycle 2, `err`=1, `result`=0, Z=1.
- With `ALU_DIV_EN`: a=100, b=7, op=100 -> `ack` cycle 18, `result`=14, `result_hi`=2. Then b=0 -> `ack` cycle 2, `result`=0xFFFF, `result_hi`=100, `err`=1.
